vga_frame_monitor: RTL and testbench
====================================

Name: vga_frame_monitor

Overview:
Sink side of the on-board VGA link. Samples the hsync/vsync/rgb stream produced by the game display path once per pixel tick and recovers pixel coordinates. Checks 640x480 timing and publishes per-frame signatures: rgb checksum and lit-pixel count. Used in-fabric as a self-check of the pong renderer and as a bench scoreboard front-end.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, front porch pixels
H_SYNC, 96, hsync low width in pixels
H_BACK, 48, back porch pixels
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, front porch lines
V_SYNC, 2, vsync low width in lines
V_BACK, 33, back porch lines

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-high reset
p_tick  in  1  pixel enable, one clk wide; all sampling happens only on these cycles
hsync  in  1  active-low horizontal sync
vsync  in  1  active-low vertical sync
rgb  in  12  pixel colour, meaningful in the visible region
pix_valid  out  1  one-clk pulse: the current sample is a visible pixel
x  out  10  recovered column 0..639, valid with pix_valid
y  out  10  recovered row 0..479, valid with pix_valid
locked  out  1  timing lock achieved
timing_err  out  1  one-clk pulse on any timing violation while not UNLOCKED
frame_done  out  1  one-clk pulse when a clean frame's results are published
frame_sum  out  16  sum of rgb over visible pixels, mod 2^16
lit_count  out  19  count of visible pixels with rgb != 0

Behaviour:
- Reset: every output 0; h_cnt, v_cnt, accumulators 0; prev sync samples 1; state UNLOCKED.
- Edges: registered previous hsync/vsync, updated only on p_tick. Falling edge is prev=1 and cur=0, evaluated on p_tick.
- h_cnt: on p_tick with hsync falling, clear to 0; else increment, saturating at 1023. Visible when h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE-1] = [144,783]; x = h_cnt-144.
- v_cnt: cleared on vsync falling; else incremented at each hsync falling edge. Visible when v_cnt in [V_SYNC+V_BACK, +V_VISIBLE-1] = [35,514]; y = v_cnt-35. If both edges fall on the same sample, vsync wins (v_cnt=0).
- Outputs x/y/pix_valid are registered on the same clk edge as the p_tick sample (latency 1 clk). pix_valid is asserted only in ACQUIRE/LOCKED.
- Errors, checked in ACQUIRE/LOCKED:
  - at hsync falling, previous h_cnt != 799;
  - at hsync rising, h_cnt != H_SYNC;
  - at vsync falling, line count != 525;
  - h_cnt saturating.
- FSM:
  - UNLOCKED -> ACQUIRE on first vsync falling.
  - ACQUIRE -> LOCKED on next vsync falling if the frame had no error. On error: timing_err pulse, clear accumulators, stay in ACQUIRE and restart the frame at the next vsync falling.
  - LOCKED -> ACQUIRE on any error, with a timing_err pulse; locked drops the same edge.
  - locked = (state==LOCKED).
- Accumulators: on each visible sample, sum += {4'b0,rgb}; lit += (rgb!=0).
- At a clean vsync falling (ACQUIRE->LOCKED or LOCKED->LOCKED): copy to frame_sum/lit_count, pulse frame_done, clear accumulators. On an errored frame, outputs hold their last values.
- Reset asserted mid-frame returns immediately to the reset state; no partial frame is published.

Optional Feature:
VGA_PROBE_EN
- Defined: adds inputs probe_x[9:0] and probe_y[9:0], and outputs probe_rgb[11:0] and probe_hit (1-clk pulse). When a visible sample matches the probe coordinates, probe_rgb is latched and probe_hit pulses. Both reset to 0.
- Undefined: these ports and the logic are absent; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg: the H_*/V_* timing constants, derived H_TOTAL=800, V_TOTAL=525, visible-start offsets, and the FSM state enum (UNLOCKED, ACQUIRE, LOCKED). The constants are shared with vga_sync.
- Sub-module sync_edge_det: p_tick-gated sample register producing fall/rise flags, with asynchronous reset to 1. Instantiated for hsync and vsync.

Test Plan:
- Reset asserted mid-line during LOCKED -> all outputs 0 next edge; locked=0; after release, no frame_done until two vsync falling edges.
- Clean vga_sync stimulus, rgb=0 -> locked rises at the 2nd vsync falling; frame_done each subsequent frame with frame_sum=0 and lit_count=0; exactly 307200 pix_valid pulses per frame.
- Pong picture: paddles 20x80 at y=100 and y=200 on both edges, ball 20x20 at (310,230), all rgb=12'h00F -> lit_count=3600, frame_sum=54000.
- White pixels only at (0,0) and (639,479) -> pix_valid with those x/y carries rgb=12'hFFF; lit_count=2; frame_sum=16'h1FFE.
- One line shortened to 799 pixels while LOCKED -> timing_err pulse at the next hsync falling; locked=0; no frame_done for that frame; relock at the next clean frame end.
- VGA_PROBE_EN, probe=(320,240), ball covering it with 12'hF00 -> probe_hit pulses once per frame with probe_rgb=12'hF00.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants for the VGA link, counted from the falling edge of sync,
// plus the lock state encoding shared by the frame monitor.
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_VIS_START = H_SYNC + H_BACK;
    localparam int V_VIS_START = V_SYNC + V_BACK;

    localparam logic [9:0] CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } mon_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Pixel-tick gated sync sampler; flags falling and rising edges of an active-low sync.
// The held sample resets high so the first low sync after reset reads as a fall.
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic p_tick,
    input  logic sync_in,
    output logic fall,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = prev_q;
        if (p_tick) begin
            prev_d = sync_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign fall = p_tick &  prev_q & ~sync_in;
    assign rise = p_tick & ~prev_q &  sync_in;

endmodule

// File: rtl/vga_frame_monitor.sv
// VGA sink: recovers pixel coordinates, checks line/frame timing and publishes per-frame
// rgb checksum and lit-pixel count. Optional coordinate probe under `VGA_PROBE_EN.
module vga_frame_monitor #(
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
`ifdef VGA_PROBE_EN
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic [11:0] probe_rgb,
    output logic        probe_hit,
`endif
    output logic        pix_valid,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        locked,
    output logic        timing_err,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [18:0] lit_count
);

    typedef vga_timing_pkg::mon_state_e state_e;

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_VIS_START = 10'(H_SYNC + H_BACK);
    localparam logic [9:0]  H_VIS_END   = 10'(H_SYNC + H_BACK + H_VISIBLE - 1);
    localparam logic [9:0]  V_VIS_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_VIS_END   = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);
    localparam logic [9:0]  H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0]  H_SYNC_W    = 10'(H_SYNC);
    localparam logic [10:0] LINES       = 11'(V_TOTAL);
    localparam logic [9:0]  CNT_MAX     = vga_timing_pkg::CNT_MAX;

    logic h_fall, h_rise, v_fall, v_rise_unused;

    sync_edge_det u_hsync_edge (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick),
        .sync_in(hsync),
        .fall   (h_fall),
        .rise   (h_rise)
    );

    sync_edge_det u_vsync_edge (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick),
        .sync_in(vsync),
        .fall   (v_fall),
        .rise   (v_rise_unused)
    );

    state_e      state_q, state_d;
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        frame_err_q, frame_err_d;
    logic [15:0] sum_q, sum_d;
    logic [18:0] lit_q, lit_d;
    logic [15:0] frame_sum_q, frame_sum_d;
    logic [18:0] lit_count_q, lit_count_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        pix_valid_q, pix_valid_d;
    logic        timing_err_q, timing_err_d;
    logic        frame_done_q, frame_done_d;

    logic        active;
    logic        visible;
    logic        err;
    logic [10:0] line_cnt;

    // h_cnt_d/v_cnt_d are the coordinates of the sample being taken this tick.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (p_tick) begin
            if (h_fall) begin
                h_cnt_d = 10'd0;
            end else if (h_cnt_q != CNT_MAX) begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
            if (v_fall) begin
                v_cnt_d = 10'd0;
            end else if (h_fall && v_cnt_q != CNT_MAX) begin
                v_cnt_d = v_cnt_q + 10'd1;
            end
        end
    end

    // Lines in the frame just ended, including one whose hsync falls with this vsync.
    assign line_cnt = {1'b0, v_cnt_q} + {10'd0, h_fall};
    assign active   = (state_q != vga_timing_pkg::UNLOCKED);
    assign visible  = p_tick
                    && (h_cnt_d >= H_VIS_START) && (h_cnt_d <= H_VIS_END)
                    && (v_cnt_d >= V_VIS_START) && (v_cnt_d <= V_VIS_END);
    assign err      = active
                    && ((h_fall && (h_cnt_q != H_LAST))
                     || (h_rise && (h_cnt_d != H_SYNC_W))
                     || (v_fall && (line_cnt != LINES))
                     || (p_tick && !h_fall && (h_cnt_q == CNT_MAX - 10'd1)));

    always_comb begin
        state_d      = state_q;
        frame_err_d  = frame_err_q;
        sum_d        = sum_q;
        lit_d        = lit_q;
        frame_sum_d  = frame_sum_q;
        lit_count_d  = lit_count_q;
        x_d          = x_q;
        y_d          = y_q;
        pix_valid_d  = 1'b0;
        timing_err_d = 1'b0;
        frame_done_d = 1'b0;

        if (active && visible) begin
            pix_valid_d = 1'b1;
            x_d         = h_cnt_d - H_VIS_START;
            y_d         = v_cnt_d - V_VIS_START;
        end

        case (state_q)
            vga_timing_pkg::UNLOCKED: begin
                if (v_fall) begin
                    state_d     = vga_timing_pkg::ACQUIRE;
                    frame_err_d = 1'b0;
                    sum_d       = 16'd0;
                    lit_d       = 19'd0;
                end
            end
            default: begin
                if (v_fall) begin
                    sum_d       = 16'd0;
                    lit_d       = 19'd0;
                    frame_err_d = 1'b0;
                    if (err || frame_err_q) begin
                        state_d      = vga_timing_pkg::ACQUIRE;
                        timing_err_d = err;
                    end else begin
                        state_d      = vga_timing_pkg::LOCKED;
                        frame_sum_d  = sum_q;
                        lit_count_d  = lit_q;
                        frame_done_d = 1'b1;
                    end
                end else if (err) begin
                    state_d      = vga_timing_pkg::ACQUIRE;
                    timing_err_d = 1'b1;
                    frame_err_d  = 1'b1;
                    sum_d        = 16'd0;
                    lit_d        = 19'd0;
                end else if (visible) begin
                    sum_d = sum_q + {4'b0000, rgb};
                    if (rgb != 12'd0) begin
                        lit_d = lit_q + 19'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= vga_timing_pkg::UNLOCKED;
            h_cnt_q      <= 10'd0;
            v_cnt_q      <= 10'd0;
            frame_err_q  <= 1'b0;
            sum_q        <= 16'd0;
            lit_q        <= 19'd0;
            frame_sum_q  <= 16'd0;
            lit_count_q  <= 19'd0;
            x_q          <= 10'd0;
            y_q          <= 10'd0;
            pix_valid_q  <= 1'b0;
            timing_err_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            frame_err_q  <= frame_err_d;
            sum_q        <= sum_d;
            lit_q        <= lit_d;
            frame_sum_q  <= frame_sum_d;
            lit_count_q  <= lit_count_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pix_valid_q  <= pix_valid_d;
            timing_err_q <= timing_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign x          = x_q;
    assign y          = y_q;
    assign locked     = (state_q == vga_timing_pkg::LOCKED);
    assign timing_err = timing_err_q;
    assign frame_done = frame_done_q;
    assign frame_sum  = frame_sum_q;
    assign lit_count  = lit_count_q;

`ifdef VGA_PROBE_EN
    logic [11:0] probe_rgb_q, probe_rgb_d;
    logic        probe_hit_q, probe_hit_d;

    always_comb begin
        probe_rgb_d = probe_rgb_q;
        probe_hit_d = 1'b0;
        if (pix_valid_d && (x_d == probe_x) && (y_d == probe_y)) begin
            probe_rgb_d = rgb;
            probe_hit_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            probe_rgb_q <= 12'd0;
            probe_hit_q <= 1'b0;
        end else begin
            probe_rgb_q <= probe_rgb_d;
            probe_hit_q <= probe_hit_d;
        end
    end

    assign probe_rgb = probe_rgb_q;
    assign probe_hit = probe_hit_q;
`endif

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor on a reduced raster (16x8 visible) so full frames stay short.
module tb_vga_frame_monitor;

    localparam int HV = 16, HF = 2, HS = 4, HB = 3;
    localparam int VV = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int HVS = HS + HB;
    localparam int VVS = VS + VB;
    localparam int PX = 8, PY = 4;

    logic        clk;
    logic        reset;
    logic        p_tick;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic        pix_valid;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        locked;
    logic        timing_err;
    logic        frame_done;
    logic [15:0] frame_sum;
    logic [18:0] lit_count;
`ifdef VGA_PROBE_EN
    logic [9:0]  probe_x;
    logic [9:0]  probe_y;
    logic [11:0] probe_rgb;
    logic        probe_hit;
`endif

    vga_frame_monitor #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .p_tick    (p_tick),
        .hsync     (hsync),
        .vsync     (vsync),
        .rgb       (rgb),
`ifdef VGA_PROBE_EN
        .probe_x   (probe_x),
        .probe_y   (probe_y),
        .probe_rgb (probe_rgb),
        .probe_hit (probe_hit),
`endif
        .pix_valid (pix_valid),
        .x         (x),
        .y         (y),
        .locked    (locked),
        .timing_err(timing_err),
        .frame_done(frame_done),
        .frame_sum (frame_sum),
        .lit_count (lit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int pat;
        int exp_locked;
        int exp_lit;
        int exp_sum;
    } frame_vec_t;

    typedef struct { int px; int py; } pix_t;
    typedef struct { int sum; int lit; } res_t;

    pix_t pix_q[$];
    res_t res_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int pix_seen = 0;
    int err_seen = 0;
    int hit_seen = 0;
    int cur_pat  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] pat_rgb(input int pat, input int px, input int py);
        case (pat)
            1: return 12'h00F;
            2: return ((px == 0 && py == 0) || (px == HV-1 && py == VV-1)) ? 12'hFFF : 12'h000;
            3: begin
                if (px <= 1 && py >= 1 && py <= 3)                 return 12'h00F;
                if (px >= HV-2 && py >= 4 && py <= 6)              return 12'h00F;
                if (px >= 7 && px <= 8 && py >= 3 && py <= 4)      return 12'h00F;
                return 12'h000;
            end
            4: return 12'hFFF;
            5: return (px >= 7 && px <= 8 && py >= 3 && py <= 4) ? 12'hF00 : 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (pix_valid) begin
                pix_seen++;
                chk("pix_expected", int'(pix_q.size() > 0), 1);
                if (pix_q.size() > 0) begin
                    pix_t p;
                    p = pix_q.pop_front();
                    chk("pix_x", int'(x), p.px);
                    chk("pix_y", int'(y), p.py);
                end
            end
            if (frame_done) begin
                chk("frame_done_expected", int'(res_q.size() > 0), 1);
                if (res_q.size() > 0) begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("frame_sum", int'(frame_sum), r.sum);
                    chk("lit_count", int'(lit_count), r.lit);
                end
            end
            if (timing_err) err_seen++;
`ifdef VGA_PROBE_EN
            if (probe_hit) begin
                hit_seen++;
                chk("probe_rgb", int'(probe_rgb), int'(pat_rgb(cur_pat, PX, PY)));
            end
`endif
        end
    end

    task automatic tick(input logic hs, input logic vs, input logic [11:0] c);
        @(negedge clk);
        hsync  = hs;
        vsync  = vs;
        rgb    = c;
        p_tick = 1'b1;
        @(negedge clk);
        p_tick = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pix_valid"},  int'(pix_valid), 0);
        chk({tag, "_x"},          int'(x), 0);
        chk({tag, "_y"},          int'(y), 0);
        chk({tag, "_locked"},     int'(locked), 0);
        chk({tag, "_timing_err"}, int'(timing_err), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_frame_sum"},  int'(frame_sum), 0);
        chk({tag, "_lit_count"},  int'(lit_count), 0);
    endtask

    // One full frame starting at the common sync fall; optional short line or mid-line reset.
    task automatic drive_frame(input int pat, input bit publish, input int exp_sum,
                               input int exp_lit, input int short_line, input int rst_line,
                               input int exp_locked);
        bit valid_on = 1'b0;
        bit aborted  = 1'b0;
        cur_pat  = pat;
        pix_seen = 0;
        err_seen = 0;
        hit_seen = 0;
        for (int v = 0; v < VT; v++) begin
            for (int h = 0; h < HT; h++) begin
                bit vis;
                logic [11:0] c;
                if (v == short_line && h == HT-1) continue;
                if (v == rst_line && h == HVS + 5 && !aborted) begin
                    @(negedge clk);
                    reset = 1'b1;
                    @(negedge clk);
                    check_reset_outputs("midreset");
                    @(negedge clk);
                    reset    = 1'b0;
                    aborted  = 1'b1;
                    valid_on = 1'b0;
                end
                vis = (h >= HVS) && (h < HVS + HV) && (v >= VVS) && (v < VVS + VV);
                c   = vis ? pat_rgb(pat, h - HVS, v - VVS) : 12'h000;
                if (vis && valid_on) pix_q.push_back('{px: h - HVS, py: v - VVS});
                tick(h >= HS, v >= VS, c);
                if (v == 0 && h == 0) begin
                    chk("locked_at_frame_start", int'(locked), exp_locked);
                    valid_on = 1'b1;
                end
                if (short_line >= 0 && v == short_line + 1 && h == 0) begin
                    chk("timing_err_after_short_line", int'(timing_err), 1);
                    chk("locked_after_err", int'(locked), 0);
                end
            end
        end
        if (!aborted) begin
            chk("pix_per_frame", pix_seen, HV * VV);
`ifdef VGA_PROBE_EN
            chk("probe_hits_per_frame", hit_seen, 1);
`endif
        end
        chk("timing_err_count", err_seen, (short_line >= 0) ? 1 : 0);
        if (publish && !aborted) res_q.push_back('{sum: exp_sum, lit: exp_lit});
    endtask

    frame_vec_t vecs[7];

    initial begin
        vecs[0] = '{pat: 0, exp_locked: 0, exp_lit: 0,   exp_sum: 0};
        vecs[1] = '{pat: 0, exp_locked: 1, exp_lit: 0,   exp_sum: 0};
        vecs[2] = '{pat: 1, exp_locked: 1, exp_lit: 128, exp_sum: 1920};
        vecs[3] = '{pat: 3, exp_locked: 1, exp_lit: 16,  exp_sum: 240};
        vecs[4] = '{pat: 2, exp_locked: 1, exp_lit: 2,   exp_sum: 16'h1FFE};
        vecs[5] = '{pat: 4, exp_locked: 1, exp_lit: 128, exp_sum: 16'hFF80};
        vecs[6] = '{pat: 5, exp_locked: 1, exp_lit: 4,   exp_sum: 16'h3C00};

        reset  = 1'b1;
        p_tick = 1'b0;
        hsync  = 1'b1;
        vsync  = 1'b1;
        rgb    = 12'h000;
`ifdef VGA_PROBE_EN
        probe_x = 10'(PX);
        probe_y = 10'(PY);
`endif
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            drive_frame(vecs[i].pat, 1'b1, vecs[i].exp_sum, vecs[i].exp_lit, -1, -1,
                        vecs[i].exp_locked);
        end

        // short line while locked: errored frame is dropped, next clean frame relocks
        drive_frame(1, 1'b0, 0, 0, 5, -1, 1);
        drive_frame(1, 1'b1, 1920, 128, -1, -1, 0);

        // mid-line reset while locked: nothing published until two vsync falls later
        drive_frame(3, 1'b0, 0, 0, -1, 6, 1);
        drive_frame(3, 1'b1, 240, 16, -1, -1, 0);
        drive_frame(0, 1'b1, 0, 0, -1, -1, 1);

        tick(1'b0, 1'b0, 12'h000);
        chk("locked_at_end", int'(locked), 1);
        repeat (4) @(negedge clk);
        chk("results_drained", res_q.size(), 0);
        chk("pixels_drained", pix_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
